// File: rtl/apb_arb_master.sv
// Two-client round-robin APB master: SETUP/ACCESS sequencing, pready waits and
// wait-state timeout. All outputs come straight from registers.
module apb_arb_master #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic [1:0]    req,
    input  logic [1:0]    req_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [DW-1:0] req1_wdata,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready,
    input  logic [DW-1:0] prdata
);

    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] TMO = WCW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q;
    logic [1:0]      gnt_q;
    logic [1:0]      done_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;
    logic            psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [AW-1:0]   paddr_q;
    logic [DW-1:0]   pwdata_q;
    logic [WCW-1:0]  wait_q;
    logic            prio_q;

    logic [1:0]      elig;
    logic            win;
    logic [WCW-1:0]  wait_d;
    logic            timeout_hit;

    // The client just finished is masked while its done pulse is high.
    always_comb begin
        elig = req & ~done_q;
        win  = 1'b0;
        if (elig == 2'b11) begin
            win = prio_q;
        end else if (elig[1]) begin
            win = 1'b1;
        end
    end

    assign wait_d      = wait_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (wait_d == TMO);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            wait_q    <= '0;
            prio_q    <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        paddr_q   <= win ? req1_addr : req0_addr;
                        pwdata_q  <= win ? req1_wdata : req0_wdata;
                        pwrite_q  <= req_write[win];
                        gnt_q     <= win ? 2'b10 : 2'b01;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        gnt_q     <= '0;
                        done_q    <= gnt_q;
                        err_q     <= ~pready;
                        if (pready && !pwrite_q) begin
                            rdata_q <= prdata;
                        end
                        prio_q    <= ~gnt_q[1];
                        state_q   <= IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule
